// File: rtl/mcycle_ctrl_pkg.sv
// Shared definitions for the multi-cycle controller: states, ALUOp/opcode constants, format decode.
// Optional JAL support is enabled by defining MCYCLE_CTRL_JAL_EN.
package mcycle_ctrl_pkg;

`ifdef MCYCLE_CTRL_JAL_EN
  localparam bit JAL_EN = 1'b1;
`else
  localparam bit JAL_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB
  } state_t;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ADDI   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [2:0] {
    FMT_R,
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_U,
    FMT_J,
    FMT_UNK
  } instr_format;

  // Registered (Moore) control word; ir_write and illegal are derived outside it.
  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic       pc_write;
    logic       pc_src;
    logic       Branch;
    logic       MemRead;
    logic       MemtoReg;
    logic       MemWrite;
    logic       ALUSrc;
    logic       RegWrite;
    logic       PC4toReg;
    logic [1:0] ALUOp;
    logic       busy;
  } ctrl_t;

  function automatic instr_format decode32_format(input logic [6:0] op);
    instr_format f;
    case (op)
      OP_RTYPE:                   f = FMT_R;
      OP_ADDI, OP_LOAD, OP_JALR:  f = FMT_I;
      OP_STORE:                   f = FMT_S;
      OP_BRANCH:                  f = FMT_B;
      OP_LUI, OP_AUIPC:           f = FMT_U;
      OP_JAL:                     f = FMT_J;
      default:                    f = FMT_UNK;
    endcase
    return f;
  endfunction

  function automatic logic op_supported(input logic [6:0] op);
    logic ok;
    case (decode32_format(op))
      FMT_R, FMT_S, FMT_B: ok = 1'b1;
      FMT_I:               ok = (op == OP_ADDI) || (op == OP_LOAD);
      FMT_J:               ok = JAL_EN;
      default:             ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mcycle_ctrl_out.sv
// Per-state Moore control decode for the multi-cycle controller (purely combinational).
// JAL handling follows MCYCLE_CTRL_JAL_EN via the package.
module mcycle_ctrl_out
  import mcycle_ctrl_pkg::*;
(
  input  state_t     i_state,
  input  logic [6:0] i_opcode,
  output ctrl_t      o_ctrl
);

  instr_format w_fmt;

  always_comb begin
    w_fmt       = decode32_format(i_opcode);
    o_ctrl      = '0;
    o_ctrl.busy = (i_state != S_FETCH);
    case (i_state)
      S_FETCH: begin
        o_ctrl.mem_req = 1'b1;
        o_ctrl.MemRead = 1'b1;
      end
      S_EXEC: begin
        case (w_fmt)
          FMT_R: o_ctrl.ALUOp = ALUOP_FUNCT;
          FMT_I, FMT_S: begin
            o_ctrl.ALUSrc = 1'b1;
            o_ctrl.ALUOp  = ALUOP_ADD;
          end
          FMT_B: begin
            o_ctrl.ALUOp  = ALUOP_SUB;
            o_ctrl.Branch = 1'b1;
            o_ctrl.pc_src = 1'b1;
          end
          FMT_J: begin
            o_ctrl.pc_write = JAL_EN;
            o_ctrl.pc_src   = JAL_EN;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        o_ctrl.mem_req = 1'b1;
        o_ctrl.iord    = 1'b1;
        if (i_opcode == OP_LOAD) begin
          o_ctrl.MemRead = 1'b1;
        end else begin
          o_ctrl.MemWrite = 1'b1;
          o_ctrl.mem_we   = 1'b1;
        end
      end
      S_WB: begin
        o_ctrl.RegWrite = 1'b1;
        o_ctrl.MemtoReg = (i_opcode == OP_LOAD);
        o_ctrl.PC4toReg = JAL_EN && (w_fmt == FMT_J);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mcycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB controller with registered outputs.
// Defining MCYCLE_CTRL_JAL_EN adds JAL (1101111) support; otherwise it decodes as illegal.
module mcycle_ctrl
  import mcycle_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic       zero,
  input  logic       mem_ack,
  output logic       mem_req,
  output logic       mem_we,
  output logic       iord,
  output logic       ir_write,
  output logic       pc_write,
  output logic       pc_src,
  output logic       Branch,
  output logic       MemRead,
  output logic       MemtoReg,
  output logic       MemWrite,
  output logic       ALUSrc,
  output logic       RegWrite,
  output logic       PC4toReg,
  output logic [1:0] ALUOp,
  output logic       busy,
  output logic       illegal
);

  state_t      r_state;
  state_t      w_state_nx;
  logic [6:0]  r_opcode;
  logic [6:0]  w_opcode_nx;
  ctrl_t       r_ctrl;
  ctrl_t       w_ctrl_nx;
  logic        w_ack;
  instr_format w_fmt;

  // An ack only counts while a request is actually being presented.
  assign w_ack       = r_ctrl.mem_req & mem_ack;
  assign w_opcode_nx = (r_state == S_DECODE) ? opcode : r_opcode;
  assign w_fmt       = decode32_format(r_opcode);

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_FETCH:  if (w_ack) w_state_nx = S_DECODE;
      S_DECODE: w_state_nx = op_supported(opcode) ? S_EXEC : S_FETCH;
      S_EXEC: begin
        case (w_fmt)
          FMT_R, FMT_J: w_state_nx = S_WB;
          FMT_I:        w_state_nx = (r_opcode == OP_ADDI) ? S_WB : S_MEM;
          FMT_S:        w_state_nx = S_MEM;
          default:      w_state_nx = S_FETCH;
        endcase
      end
      S_MEM:    if (w_ack) w_state_nx = (r_opcode == OP_LOAD) ? S_WB : S_FETCH;
      S_WB:     w_state_nx = S_FETCH;
      default:  w_state_nx = S_FETCH;
    endcase
  end

  // Outputs are decoded from the next state and registered, so they line up with r_state
  // and come out of reset all-zero; the first fetch request appears one edge after release.
  mcycle_ctrl_out u_out (
    .i_state  (w_state_nx),
    .i_opcode (w_opcode_nx),
    .o_ctrl   (w_ctrl_nx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_FETCH;
      r_opcode <= '0;
      r_ctrl   <= '0;
    end else begin
      r_state  <= w_state_nx;
      r_opcode <= w_opcode_nx;
      r_ctrl   <= w_ctrl_nx;
    end
  end

  assign mem_req  = r_ctrl.mem_req;
  assign mem_we   = r_ctrl.mem_we;
  assign iord     = r_ctrl.iord;
  assign ir_write = w_ack & ~r_ctrl.iord;
  assign pc_write = r_ctrl.pc_write | (r_ctrl.Branch & zero) | (w_ack & ~r_ctrl.iord);
  assign pc_src   = r_ctrl.pc_src;
  assign Branch   = r_ctrl.Branch;
  assign MemRead  = r_ctrl.MemRead;
  assign MemtoReg = r_ctrl.MemtoReg;
  assign MemWrite = r_ctrl.MemWrite;
  assign ALUSrc   = r_ctrl.ALUSrc;
  assign RegWrite = r_ctrl.RegWrite;
  assign PC4toReg = r_ctrl.PC4toReg;
  assign ALUOp    = r_ctrl.ALUOp;
  assign busy     = r_ctrl.busy;
  // The IR only holds a valid opcode during DECODE, so illegal is flagged from the live field.
  assign illegal  = (r_state == S_DECODE) & ~op_supported(opcode);

endmodule
